// File: rtl/lsu.sv
// Load/store unit: turns execute results into one 64-bit data-bus access and
// returns aligned, extended load data. Optional misalign trap: LSU_MISALIGN_TRAP_EN.

`ifndef MEMOP_LEN
`define MEMOP_LEN  4
`define MEMOP_NONE 4'd0
`define MEMOP_LB   4'd1
`define MEMOP_LBU  4'd2
`define MEMOP_LH   4'd3
`define MEMOP_LHU  4'd4
`define MEMOP_LW   4'd5
`define MEMOP_LWU  4'd6
`define MEMOP_LD   4'd7
`define MEMOP_SB   4'd8
`define MEMOP_SH   4'd9
`define MEMOP_SW   4'd10
`define MEMOP_SD   4'd11
`endif

module lsu #(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_result,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [4:0]            in_rd_idx,
  input  logic [`MEMOP_LEN-1:0] in_mem_op,
  output logic                  dbus_req_valid,
  input  logic                  dbus_req_ready,
  output logic [XLEN-1:0]       dbus_addr,
  output logic                  dbus_we,
  output logic [63:0]           dbus_wdata,
  output logic [7:0]            dbus_wstrb,
  input  logic                  dbus_rvalid,
  input  logic [63:0]           dbus_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd_idx,
  output logic [XLEN-1:0]       wb_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_WB
  } state_t;

  state_t state_reg, state_next;

  logic [XLEN-1:0]       addr_reg;
  logic [63:0]           wdata_reg;
  logic [7:0]            wstrb_reg;
  logic                  we_reg;
  logic [`MEMOP_LEN-1:0] op_reg;
  logic [4:0]            rd_reg;
  logic [XLEN-1:0]       wb_data_reg;

  logic       in_is_load;
  logic       in_is_store;
  logic [1:0] in_size;
  logic [2:0] in_off;
  logic [7:0] base_strobe;
  logic [15:0] strobe_wide;
  logic [63:0] load_shift;
  logic [63:0] load_ext;
  logic       accept;

  assign in_off = in_result[2:0];
  assign accept = (state_reg == S_IDLE) && in_valid;

  always_comb begin
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_size     = 2'd0;
    case (in_mem_op)
      `MEMOP_LB, `MEMOP_LBU: begin in_is_load  = 1'b1; in_size = 2'd0; end
      `MEMOP_LH, `MEMOP_LHU: begin in_is_load  = 1'b1; in_size = 2'd1; end
      `MEMOP_LW, `MEMOP_LWU: begin in_is_load  = 1'b1; in_size = 2'd2; end
      `MEMOP_LD:             begin in_is_load  = 1'b1; in_size = 2'd3; end
      `MEMOP_SB:             begin in_is_store = 1'b1; in_size = 2'd0; end
      `MEMOP_SH:             begin in_is_store = 1'b1; in_size = 2'd1; end
      `MEMOP_SW:             begin in_is_store = 1'b1; in_size = 2'd2; end
      `MEMOP_SD:             begin in_is_store = 1'b1; in_size = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    case (in_size)
      2'd0:    base_strobe = 8'h01;
      2'd1:    base_strobe = 8'h03;
      2'd2:    base_strobe = 8'h0F;
      default: base_strobe = 8'hFF;
    endcase
  end

  // Strobe bits pushed past lane 7 by a misaligned offset are simply dropped.
  assign strobe_wide = {8'h00, base_strobe} << in_off;

`ifdef LSU_MISALIGN_TRAP_EN
  logic in_misalign;
  logic misalign_reg;

  always_comb begin
    in_misalign = 1'b0;
    if (in_is_load || in_is_store) begin
      case (in_size)
        2'd1:    in_misalign = in_off[0];
        2'd2:    in_misalign = |in_off[1:0];
        2'd3:    in_misalign = |in_off;
        default: in_misalign = 1'b0;
      endcase
    end
  end
`endif

  // Load extraction uses the captured address, not the live execute input.
  assign load_shift = dbus_rdata >> {addr_reg[2:0], 3'b000};

  always_comb begin
    case (op_reg)
      `MEMOP_LB:  load_ext = {{56{load_shift[7]}},  load_shift[7:0]};
      `MEMOP_LBU: load_ext = {56'd0,                load_shift[7:0]};
      `MEMOP_LH:  load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
      `MEMOP_LHU: load_ext = {48'd0,                load_shift[15:0]};
      `MEMOP_LW:  load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
      `MEMOP_LWU: load_ext = {32'd0,                load_shift[31:0]};
      default:    load_ext = load_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    in_ready       = 1'b0;
    dbus_req_valid = 1'b0;
    wb_valid       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!(in_is_load || in_is_store)) begin
            state_next = S_WB;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (in_misalign) begin
            state_next = S_WB;
`endif
          end else begin
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        dbus_req_valid = 1'b1;
        if (dbus_req_ready) begin
          state_next = we_reg ? S_WB : S_RESP;
        end
      end
      S_RESP: begin
        if (dbus_rvalid) begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      we_reg      <= 1'b0;
      op_reg      <= `MEMOP_NONE;
      rd_reg      <= '0;
      wb_data_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_reg    <= in_result;
        wdata_reg   <= in_rs2_data << {in_off, 3'b000};
        wstrb_reg   <= strobe_wide[7:0];
        we_reg      <= in_is_store;
        op_reg      <= in_mem_op;
        rd_reg      <= in_is_store ? 5'd0 : in_rd_idx;
        wb_data_reg <= (in_is_load || in_is_store) ? '0 : in_result;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_reg <= in_misalign;
        if (in_misalign) begin
          rd_reg <= 5'd0;
        end
`endif
      end
      if ((state_reg == S_RESP) && dbus_rvalid) begin
        wb_data_reg <= load_ext;
      end
    end
  end

  // Data outputs are forced to zero whenever their valid is low.
  assign dbus_addr  = dbus_req_valid ? {addr_reg[XLEN-1:3], 3'b000} : '0;
  assign dbus_we    = dbus_req_valid & we_reg;
  assign dbus_wdata = dbus_req_valid ? wdata_reg : 64'd0;
  assign dbus_wstrb = dbus_req_valid ? wstrb_reg : 8'd0;
  assign wb_rd_idx  = wb_valid ? rd_reg : 5'd0;
  assign wb_data    = wb_valid ? wb_data_reg : '0;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign   = wb_valid & misalign_reg;
`endif

endmodule
